pe_filter_ingress: RTL and testbench

Clocked PE-side ingress stage that consumes the 57-bit filter-row packets emitted by the filter memory node after they traverse the NoC. It accepts one packet addressed to this PE, unpacks the 40-bit payload into five 8-bit weights, and replays that row to the local MAC array once per convolution window, `REUSE` times. It then re-arms for the next filter row.

---
 rtl/pe_filter_ingress.sv | 122 ++++++++++++
 tb/tb_pe_filter_ingress.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_filter_ingress.sv
// PE-side filter ingress: accepts one filter-row packet addressed to this node,
// unpacks it into DEPTH_F weights and replays the row REUSE times to the MAC.
//
// state  | meaning
// IDLE   | first cycle after reset, arms the packet port
// LOAD   | pkt_ready high, waiting for a packet; misaddressed ones are dropped
// STREAM | presenting weights w_idx 0..DEPTH_F-1, REUSE passes
module pe_filter_ingress #(
    parameter int         WIDTH_packet  = 57,
    parameter int         WIDTH_payload = 40,
    parameter int         WIDTH_data    = 8,
    parameter int         DEPTH_F       = 5,
    parameter logic [3:0] NODE_ID       = 4'd1,
    parameter int         REUSE         = 21
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [WIDTH_packet-1:0] pkt_data,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [WIDTH_data-1:0]   w_data,
    output logic [2:0]              w_idx,
    output logic                    w_last,
    output logic                    row_done,
    output logic                    drop,
    output logic [3:0]              src_id
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    localparam logic [2:0] LAST_IDX  = 3'(DEPTH_F - 1);
    localparam logic [7:0] LAST_PASS = 8'(REUSE - 1);

    state_t                state_q, state_d;
    logic [WIDTH_data-1:0] weight_q [DEPTH_F];
    logic [7:0]            pass_q;
    logic                  pkt_ready_d, w_valid_d, row_done_d, drop_d;

    logic [WIDTH_payload-1:0] payload;
    logic                     accept, dest_hit, load_hit, hs, row_end;

    // Routing header is consumed by the NoC; only dest and source matter here.
    logic [8:0] unused_hdr;
    assign unused_hdr = {pkt_data[WIDTH_packet-1], pkt_data[47:40]};

    assign payload  = pkt_data[WIDTH_payload-1:0];
    assign accept   = pkt_valid & pkt_ready;
    assign dest_hit = (pkt_data[51:48] == NODE_ID);
    assign load_hit = accept & dest_hit;
    assign hs       = w_valid & w_ready;
    assign row_end  = hs && (w_idx == LAST_IDX) && (pass_q == LAST_PASS);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = LOAD;
            LOAD:    if (load_hit) state_d = STREAM;
            STREAM:  if (row_end)  state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_ready_d = (state_d == LOAD);
        w_valid_d   = (state_d == STREAM);
        row_done_d  = (state_q == STREAM) && row_end;
        drop_d      = (state_q == LOAD) && accept && !dest_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_ready <= 1'b0;
            w_valid   <= 1'b0;
            row_done  <= 1'b0;
            drop      <= 1'b0;
        end else begin
            pkt_ready <= pkt_ready_d;
            w_valid   <= w_valid_d;
            row_done  <= row_done_d;
            drop      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH_F; k++) weight_q[k] <= '0;
            src_id <= '0;
            w_idx  <= '0;
            pass_q <= '0;
        end else if ((state_q == LOAD) && load_hit) begin
            for (int k = 0; k < DEPTH_F; k++)
                weight_q[k] <= payload[k*WIDTH_data +: WIDTH_data];
            src_id <= pkt_data[55:52];
            w_idx  <= '0;
            pass_q <= '0;
        end else if (hs) begin
            // pass_q overshoots to REUSE after the last pass; cleared on next load
            if (w_idx == LAST_IDX) begin
                w_idx  <= '0;
                pass_q <= pass_q + 8'd1;
            end else begin
                w_idx <= w_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int k = 0; k < DEPTH_F; k++)
            if (w_idx == 3'(k)) w_data = weight_q[k];
    end

    assign w_last = (w_idx == LAST_IDX);

endmodule

// File: tb/tb_pe_filter_ingress.sv
// Directed bench for pe_filter_ingress: one instance at REUSE=2, one at REUSE=1.
module tb_pe_filter_ingress;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid, pkt_ready, w_valid, w_ready, w_last, row_done, drop;
    logic [56:0] pkt_data;
    logic [7:0]  w_data;
    logic [2:0]  w_idx;
    logic [3:0]  src_id;

    logic        pkt_valid_b, pkt_ready_b, w_valid_b, w_ready_b, w_last_b, row_done_b, drop_b;
    logic [56:0] pkt_data_b;
    logic [7:0]  w_data_b;
    logic [2:0]  w_idx_b;
    logic [3:0]  src_id_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pe_filter_ingress #(.NODE_ID(4'd1), .REUSE(2)) u_dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_data(pkt_data), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_idx(w_idx), .w_last(w_last), .row_done(row_done), .drop(drop), .src_id(src_id)
    );

    pe_filter_ingress #(.NODE_ID(4'd1), .REUSE(1)) u_dut_r1 (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid_b), .pkt_ready(pkt_ready_b),
        .pkt_data(pkt_data_b), .w_valid(w_valid_b), .w_ready(w_ready_b), .w_data(w_data_b),
        .w_idx(w_idx_b), .w_last(w_last_b), .row_done(row_done_b), .drop(drop_b),
        .src_id(src_id_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [56:0] mk_pkt(input logic [3:0] src, input logic [3:0] dest,
                                           input logic [39:0] pl, input logic [8:0] junk);
        return {junk[8], src, dest, junk[7:0], pl};
    endfunction

    task automatic send_pkt(input logic [56:0] p);
        int waited;
        waited    = 0;
        pkt_data  = p;
        pkt_valid = 1'b1;
        while (!pkt_ready && waited < 20) begin
            step();
            waited++;
        end
        check("accept_ready", 64'(pkt_ready), 64'd1);
        step();
        pkt_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pkt_ready"}, 64'(pkt_ready), 64'd0);
        check({tag, "_w_valid"},   64'(w_valid),   64'd0);
        check({tag, "_w_last"},    64'(w_last),    64'd0);
        check({tag, "_row_done"},  64'(row_done),  64'd0);
        check({tag, "_drop"},      64'(drop),      64'd0);
        check({tag, "_w_idx"},     64'(w_idx),     64'd0);
        check({tag, "_w_data"},    64'(w_data),    64'd0);
        check({tag, "_src_id"},    64'(src_id),    64'd0);
    endtask

    // Streams a full loaded row with w_ready high, optionally stalling before beat stall_pos.
    task automatic stream_row(input string tag, input logic [39:0] pl, input int reps,
                              input int stall_pos, input int stall_len);
        int k;
        logic [7:0] exp_w;
        for (int t = 0; t < reps * 5; t++) begin
            k     = t % 5;
            exp_w = pl[8*k +: 8];
            if (t == stall_pos) begin
                w_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check({tag, "_stall_valid"}, 64'(w_valid), 64'd1);
                    check({tag, "_stall_data"},  64'(w_data),  64'(exp_w));
                    check({tag, "_stall_idx"},   64'(w_idx),   64'(k));
                    check({tag, "_stall_last"},  64'(w_last),  64'(k == 4));
                    step();
                end
                w_ready = 1'b1;
            end
            check($sformatf("%s_valid_%0d", tag, t), 64'(w_valid),   64'd1);
            check($sformatf("%s_data_%0d", tag, t),  64'(w_data),    64'(exp_w));
            check($sformatf("%s_idx_%0d", tag, t),   64'(w_idx),     64'(k));
            check($sformatf("%s_last_%0d", tag, t),  64'(w_last),    64'(k == 4));
            check($sformatf("%s_rdy_%0d", tag, t),   64'(pkt_ready), 64'd0);
            check($sformatf("%s_done_%0d", tag, t),  64'(row_done),  64'd0);
            step();
        end
        check({tag, "_row_done"},  64'(row_done),  64'd1);
        check({tag, "_pkt_ready"}, 64'(pkt_ready), 64'd1);
        check({tag, "_end_valid"}, 64'(w_valid),   64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_b [5];
        exp_b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h80};

        rst = 1'b1; pkt_valid = 1'b0; pkt_data = '0; w_ready = 1'b1;
        pkt_valid_b = 1'b0; pkt_data_b = '0; w_ready_b = 1'b1;
        step(); step();
        check_reset_vals("rst");

        rst = 1'b0;
        check("idle_ready", 64'(pkt_ready), 64'd0);
        step();
        check("load_ready", 64'(pkt_ready), 64'd1);

        // basic load, REUSE=2
        send_pkt(mk_pkt(4'd11, 4'd1, 40'h0504030201, 9'h000));
        check("basic_src", 64'(src_id), 64'd11);
        stream_row("basic", 40'h0504030201, 2, -1, 0);
        step();
        check("basic_done_once", 64'(row_done), 64'd0);

        // misroute, then back-to-back drops
        send_pkt(mk_pkt(4'd2, 4'd3, 40'h1122334455, 9'h1FF));
        check("drop_pulse", 64'(drop),      64'd1);
        check("drop_valid", 64'(w_valid),   64'd0);
        check("drop_ready", 64'(pkt_ready), 64'd1);
        step();
        check("drop_clear", 64'(drop),   64'd0);
        check("drop_src",   64'(src_id), 64'd11);
        pkt_valid = 1'b1;
        pkt_data  = mk_pkt(4'd7, 4'd3, 40'h0, 9'h0AA);
        step();
        check("drop_b2b_0", 64'(drop), 64'd1);
        step();
        check("drop_b2b_1", 64'(drop), 64'd1);
        pkt_valid = 1'b0;
        step();
        check("drop_b2b_end", 64'(drop),    64'd0);
        check("drop_b2b_wv",  64'(w_valid), 64'd0);

        // following good packet with junk header bits, checks bit order
        send_pkt(mk_pkt(4'd4, 4'd1, 40'h8000000001, 9'h155));
        check("order_src", 64'(src_id), 64'd4);
        stream_row("order", 40'h8000000001, 2, -1, 0);

        // backpressure at w_idx=2 for 3 cycles
        send_pkt(mk_pkt(4'd11, 4'd1, 40'h0504030201, 9'h000));
        stream_row("bp", 40'h0504030201, 2, 2, 3);

        // pkt_valid held through STREAM, then back-to-back row
        send_pkt(mk_pkt(4'd5, 4'd1, 40'hFFEEDDCCBB, 9'h000));
        pkt_valid = 1'b1;
        pkt_data  = mk_pkt(4'd6, 4'd1, 40'h0A0B0C0D0E, 9'h000);
        stream_row("blk1", 40'hFFEEDDCCBB, 2, -1, 0);
        check("blk_src_hold", 64'(src_id), 64'd5);
        step();
        pkt_valid = 1'b0;
        check("blk2_src",   64'(src_id), 64'd6);
        check("blk2_first", 64'(w_data), 64'h0E);
        stream_row("blk2", 40'h0A0B0C0D0E, 2, -1, 0);

        // reset at pass 1, w_idx 3, with handshake in flight
        send_pkt(mk_pkt(4'd9, 4'd1, 40'h0504030201, 9'h000));
        repeat (8) step();
        check("mid_idx", 64'(w_idx), 64'd3);
        rst = 1'b1;
        step();
        check_reset_vals("mid_rst");
        rst = 1'b0;
        step();
        check("mid_no_done", 64'(row_done),  64'd0);
        check("mid_ready",   64'(pkt_ready), 64'd1);
        send_pkt(mk_pkt(4'd2, 4'd1, 40'hFFEEDDCCBB, 9'h000));
        stream_row("mid_new", 40'hFFEEDDCCBB, 2, -1, 0);

        // REUSE=1 instance: exactly five beats, bit order 01,00,00,00,80
        pkt_data_b  = mk_pkt(4'd3, 4'd1, 40'h8000000001, 9'h000);
        pkt_valid_b = 1'b1;
        check("r1_ready", 64'(pkt_ready_b), 64'd1);
        step();
        pkt_valid_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("r1_valid_%0d", k), 64'(w_valid_b),  64'd1);
            check($sformatf("r1_data_%0d", k),  64'(w_data_b),   64'(exp_b[k]));
            check($sformatf("r1_last_%0d", k),  64'(w_last_b),   64'(k == 4));
            check($sformatf("r1_done_%0d", k),  64'(row_done_b), 64'd0);
            step();
        end
        check("r1_row_done", 64'(row_done_b),  64'd1);
        check("r1_end_wv",   64'(w_valid_b),   64'd0);
        check("r1_rearm",    64'(pkt_ready_b), 64'd1);
        check("r1_src",      64'(src_id_b),    64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
